id_ex_stage: RTL and testbench

// ID/EX pipeline register with load-use hazard detection, flush and hold control for the RV32I pipeline.

---
 rtl/id_ex_stage.sv | 107 ++++++++++
 tb/tb_id_ex_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I pipeline: it detects load-use hazards, applies flush and hold, and writes WB results through to latched operands.
// Latency is one cycle from ID to EX. The stage holds while MEM stalls and inserts one bubble for each load-use hazard.
module id_ex_stage #(
  parameter int XLEN     = 32,
  parameter int XADDR    = 5,
  parameter int ALU_OP_W = 4,
  parameter int CNT_W    = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid_id,
  input  logic [XLEN-1:0]     i_pc_id,
  input  logic [XLEN-1:0]     i_rs1_id,
  input  logic [XLEN-1:0]     i_rs2_id,
  input  logic [XADDR-1:0]    i_rs1_addr_id,
  input  logic [XADDR-1:0]    i_rs2_addr_id,
  input  logic                i_uses_rs1_id,
  input  logic                i_uses_rs2_id,
  input  logic [XADDR-1:0]    i_rd_addr_id,
  input  logic                i_rd_wr_en_id,
  input  logic                i_is_load_id,
  input  logic [XLEN-1:0]     i_imm_id,
  input  logic [ALU_OP_W-1:0] i_alu_op_id,
  input  logic                i_flush,
  input  logic                i_stall_mem,
  input  logic [XLEN-1:0]     i_rd_wb,
  input  logic [XADDR-1:0]    i_rd_addr_wb,
  input  logic                i_rd_wb_wr_en,
  output logic                o_stall_id,
  output logic                or_valid_ex,
  output logic [XLEN-1:0]     or_pc_ex,
  output logic [XLEN-1:0]     or_rs1_ex,
  output logic [XLEN-1:0]     or_rs2_ex,
  output logic [XLEN-1:0]     or_imm_ex,
  output logic [XADDR-1:0]    or_rs1_addr_ex,
  output logic [XADDR-1:0]    or_rs2_addr_ex,
  output logic [XADDR-1:0]    or_rd_addr_ex,
  output logic                or_rd_wr_en_ex,
  output logic                or_is_load_ex,
  output logic [ALU_OP_W-1:0] or_alu_op_ex,
  output logic [CNT_W-1:0]    or_stall_cnt,
  output logic [CNT_W-1:0]    or_flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic            w_luh;
  logic            w_wb_vld;
  logic [XLEN-1:0] w_rs1_fwd;
  logic [XLEN-1:0] w_rs2_fwd;

  // An x0 write never sets or_rd_wr_en_ex, so rd==0 can never raise a hazard.
  assign w_luh = or_valid_ex & or_is_load_ex & or_rd_wr_en_ex & i_valid_id &
                 ((i_uses_rs1_id & (i_rs1_addr_id == or_rd_addr_ex)) |
                  (i_uses_rs2_id & (i_rs2_addr_id == or_rd_addr_ex)));

  assign o_stall_id = i_stall_mem | (w_luh & ~i_flush);

  assign w_wb_vld  = i_rd_wb_wr_en & (i_rd_addr_wb != '0);
  assign w_rs1_fwd = (w_wb_vld && (i_rd_addr_wb == i_rs1_addr_id)) ? i_rd_wb : i_rs1_id;
  assign w_rs2_fwd = (w_wb_vld && (i_rd_addr_wb == i_rs2_addr_id)) ? i_rd_wb : i_rs2_id;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      or_valid_ex    <= 1'b0;
      or_pc_ex       <= '0;
      or_rs1_ex      <= '0;
      or_rs2_ex      <= '0;
      or_imm_ex      <= '0;
      or_rs1_addr_ex <= '0;
      or_rs2_addr_ex <= '0;
      or_rd_addr_ex  <= '0;
      or_rd_wr_en_ex <= 1'b0;
      or_is_load_ex  <= 1'b0;
      or_alu_op_ex   <= '0;
      or_stall_cnt   <= '0;
      or_flush_cnt   <= '0;
    end else if (i_stall_mem) begin
      // The writer may retire while we are held, so refresh the held operands.
      if (w_wb_vld && (i_rd_addr_wb == or_rs1_addr_ex)) or_rs1_ex <= i_rd_wb;
      if (w_wb_vld && (i_rd_addr_wb == or_rs2_addr_ex)) or_rs2_ex <= i_rd_wb;
    end else if (i_flush) begin
      or_valid_ex    <= 1'b0;
      or_rd_wr_en_ex <= 1'b0;
      or_is_load_ex  <= 1'b0;
      if (or_flush_cnt != '1) or_flush_cnt <= or_flush_cnt + CNT_ONE;
    end else if (w_luh) begin
      or_valid_ex    <= 1'b0;
      or_rd_wr_en_ex <= 1'b0;
      or_is_load_ex  <= 1'b0;
      if (or_stall_cnt != '1) or_stall_cnt <= or_stall_cnt + CNT_ONE;
    end else begin
      or_valid_ex    <= i_valid_id;
      or_pc_ex       <= i_pc_id;
      or_rs1_ex      <= w_rs1_fwd;
      or_rs2_ex      <= w_rs2_fwd;
      or_imm_ex      <= i_imm_id;
      or_rs1_addr_ex <= i_rs1_addr_id;
      or_rs2_addr_ex <= i_rs2_addr_id;
      or_rd_addr_ex  <= i_rd_addr_id;
      or_rd_wr_en_ex <= i_rd_wr_en_id & i_valid_id & (i_rd_addr_id != '0);
      or_is_load_ex  <= i_is_load_id & i_valid_id;
      or_alu_op_ex   <= i_alu_op_id;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table plus reset and counter-saturation sequences.
module tb_id_ex_stage;

  logic        i_clk = 1'b0;
  logic        i_rst, i_valid_id, i_uses_rs1_id, i_uses_rs2_id, i_rd_wr_en_id, i_is_load_id;
  logic        i_flush, i_stall_mem, i_rd_wb_wr_en;
  logic [31:0] i_pc_id, i_rs1_id, i_rs2_id, i_imm_id, i_rd_wb;
  logic [4:0]  i_rs1_addr_id, i_rs2_addr_id, i_rd_addr_id, i_rd_addr_wb;
  logic [3:0]  i_alu_op_id;

  logic        o_stall_id, or_valid_ex, or_rd_wr_en_ex, or_is_load_ex;
  logic [31:0] or_pc_ex, or_rs1_ex, or_rs2_ex, or_imm_ex;
  logic [4:0]  or_rs1_addr_ex, or_rs2_addr_ex, or_rd_addr_ex;
  logic [3:0]  or_alu_op_ex;
  logic [15:0] or_stall_cnt, or_flush_cnt;

  logic        s_stall_id, s_valid_ex, s_rd_wr_en_ex, s_is_load_ex;
  logic [31:0] s_pc_ex, s_rs1_ex, s_rs2_ex, s_imm_ex;
  logic [4:0]  s_rs1_addr_ex, s_rs2_addr_ex, s_rd_addr_ex;
  logic [3:0]  s_alu_op_ex;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  id_ex_stage dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid_id(i_valid_id), .i_pc_id(i_pc_id),
    .i_rs1_id(i_rs1_id), .i_rs2_id(i_rs2_id), .i_rs1_addr_id(i_rs1_addr_id),
    .i_rs2_addr_id(i_rs2_addr_id), .i_uses_rs1_id(i_uses_rs1_id), .i_uses_rs2_id(i_uses_rs2_id),
    .i_rd_addr_id(i_rd_addr_id), .i_rd_wr_en_id(i_rd_wr_en_id), .i_is_load_id(i_is_load_id),
    .i_imm_id(i_imm_id), .i_alu_op_id(i_alu_op_id), .i_flush(i_flush), .i_stall_mem(i_stall_mem),
    .i_rd_wb(i_rd_wb), .i_rd_addr_wb(i_rd_addr_wb), .i_rd_wb_wr_en(i_rd_wb_wr_en),
    .o_stall_id(o_stall_id), .or_valid_ex(or_valid_ex), .or_pc_ex(or_pc_ex),
    .or_rs1_ex(or_rs1_ex), .or_rs2_ex(or_rs2_ex), .or_imm_ex(or_imm_ex),
    .or_rs1_addr_ex(or_rs1_addr_ex), .or_rs2_addr_ex(or_rs2_addr_ex), .or_rd_addr_ex(or_rd_addr_ex),
    .or_rd_wr_en_ex(or_rd_wr_en_ex), .or_is_load_ex(or_is_load_ex), .or_alu_op_ex(or_alu_op_ex),
    .or_stall_cnt(or_stall_cnt), .or_flush_cnt(or_flush_cnt)
  );

  // Narrow-counter copy so saturation is reachable in a few cycles.
  id_ex_stage #(.CNT_W(2)) u_sat (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid_id(i_valid_id), .i_pc_id(i_pc_id),
    .i_rs1_id(i_rs1_id), .i_rs2_id(i_rs2_id), .i_rs1_addr_id(i_rs1_addr_id),
    .i_rs2_addr_id(i_rs2_addr_id), .i_uses_rs1_id(i_uses_rs1_id), .i_uses_rs2_id(i_uses_rs2_id),
    .i_rd_addr_id(i_rd_addr_id), .i_rd_wr_en_id(i_rd_wr_en_id), .i_is_load_id(i_is_load_id),
    .i_imm_id(i_imm_id), .i_alu_op_id(i_alu_op_id), .i_flush(i_flush), .i_stall_mem(i_stall_mem),
    .i_rd_wb(i_rd_wb), .i_rd_addr_wb(i_rd_addr_wb), .i_rd_wb_wr_en(i_rd_wb_wr_en),
    .o_stall_id(s_stall_id), .or_valid_ex(s_valid_ex), .or_pc_ex(s_pc_ex),
    .or_rs1_ex(s_rs1_ex), .or_rs2_ex(s_rs2_ex), .or_imm_ex(s_imm_ex),
    .or_rs1_addr_ex(s_rs1_addr_ex), .or_rs2_addr_ex(s_rs2_addr_ex), .or_rd_addr_ex(s_rd_addr_ex),
    .or_rd_wr_en_ex(s_rd_wr_en_ex), .or_is_load_ex(s_is_load_ex), .or_alu_op_ex(s_alu_op_ex),
    .or_stall_cnt(s_stall_cnt), .or_flush_cnt(s_flush_cnt)
  );

  typedef struct {
    logic [31:0] v, pc, rs1, rs2, a1, a2, u1, u2, rd, we, ld, imm, op, fl, sm, wbd, wba, wbe;
    logic [31:0] es, ev, epc, ers1, ers2, erd, ewe, eld, eimm, eop, ecs, ecf;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t t);
    i_valid_id = t.v[0];      i_pc_id = t.pc;           i_rs1_id = t.rs1;   i_rs2_id = t.rs2;
    i_rs1_addr_id = t.a1[4:0]; i_rs2_addr_id = t.a2[4:0]; i_uses_rs1_id = t.u1[0];
    i_uses_rs2_id = t.u2[0];  i_rd_addr_id = t.rd[4:0];  i_rd_wr_en_id = t.we[0];
    i_is_load_id = t.ld[0];   i_imm_id = t.imm;         i_alu_op_id = t.op[3:0];
    i_flush = t.fl[0];        i_stall_mem = t.sm[0];    i_rd_wb = t.wbd;
    i_rd_addr_wb = t.wba[4:0]; i_rd_wb_wr_en = t.wbe[0];
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] rd, input logic ld, input logic fl);
    i_valid_id = v; i_pc_id = pc; i_rs1_id = 32'h0; i_rs2_id = 32'h0;
    i_rs1_addr_id = a1; i_rs2_addr_id = a2; i_uses_rs1_id = 1'b1; i_uses_rs2_id = 1'b1;
    i_rd_addr_id = rd; i_rd_wr_en_id = 1'b1; i_is_load_id = ld; i_imm_id = 32'h0; i_alu_op_id = 4'h0;
    i_flush = fl; i_stall_mem = 1'b0; i_rd_wb = 32'h0; i_rd_addr_wb = 5'd0; i_rd_wb_wr_en = 1'b0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    // v pc rs1 rs2 a1 a2 u1 u2 rd we ld imm op fl sm wbd wba wbe | es ev epc ers1 ers2 erd ewe eld eimm eop ecs ecf
    vecs[0]  = '{1,'h100,0,0,0,0,1,0,5,1,0,5,0, 0,0,0,0,0,          0,1,'h100,0,0,5,1,0,5,0,0,0};
    vecs[1]  = '{1,'h104,'h11,0,1,0,1,0,3,1,1,0,1, 0,0,0,0,0,       0,1,'h104,'h11,0,3,1,1,0,1,0,0};
    vecs[2]  = '{1,'h108,'h33,'h11,3,1,1,1,4,1,0,0,2, 0,0,0,0,0,    1,0,0,0,0,0,0,0,0,0,1,0};
    vecs[3]  = '{1,'h108,'h33,'h11,3,1,1,1,4,1,0,0,2, 0,0,'h77,3,1, 0,1,'h108,'h77,'h11,4,1,0,0,2,1,0};
    vecs[4]  = '{1,'h10C,'h22,0,2,0,1,0,0,1,1,4,1, 0,0,0,0,0,       0,1,'h10C,'h22,0,0,0,1,4,1,1,0};
    vecs[5]  = '{1,'h110,0,0,0,0,1,1,6,1,0,0,2, 0,0,0,0,0,          0,1,'h110,0,0,6,1,0,0,2,1,0};
    vecs[6]  = '{1,'h114,'h11,0,1,0,1,0,7,1,1,0,1, 0,0,0,0,0,       0,1,'h114,'h11,0,7,1,1,0,1,1,0};
    vecs[7]  = '{1,'h118,'h11,'h55,1,7,1,1,8,1,0,0,3, 1,0,0,0,0,    0,0,0,0,0,0,0,0,0,0,1,1};
    vecs[8]  = '{0,'h118,'h11,'h55,1,7,1,1,8,1,0,0,3, 0,0,0,0,0,    0,0,0,0,0,0,0,0,0,0,1,1};
    vecs[9]  = '{1,'h11C,0,'h70,0,7,1,1,9,1,0,0,2, 0,0,0,0,0,       0,1,'h11C,0,'h70,9,1,0,0,2,1,1};
    vecs[10] = '{1,'h200,0,0,0,0,1,0,10,1,0,1,0, 0,1,'hDEAD,7,1,    1,1,'h11C,0,'hDEAD,9,1,0,0,2,1,1};
    vecs[11] = '{1,'h200,0,0,0,0,1,0,10,1,0,1,0, 0,1,'hDEAD,7,1,    1,1,'h11C,0,'hDEAD,9,1,0,0,2,1,1};
    vecs[12] = '{1,'h200,0,0,0,0,1,0,10,1,0,1,0, 0,1,'hDEAD,7,1,    1,1,'h11C,0,'hDEAD,9,1,0,0,2,1,1};
    vecs[13] = '{1,'h200,0,0,0,0,1,0,10,1,0,1,0, 0,0,'hBAD,0,1,     0,1,'h200,0,0,10,1,0,1,0,1,1};

    set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    i_rst = 1'b1;
    tick();
    tick();
    chk("rst_valid", {31'd0, or_valid_ex}, 0);
    chk("rst_pc", or_pc_ex, 0);
    chk("rst_rd_wr_en", {31'd0, or_rd_wr_en_ex}, 0);
    chk("rst_stall_cnt", {16'd0, or_stall_cnt}, 0);
    chk("rst_flush_cnt", {16'd0, or_flush_cnt}, 0);
    chk("rst_stall_id", {31'd0, o_stall_id}, 0);
    i_rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_stall_id", i), {31'd0, o_stall_id}, vecs[i].es);
      tick();
      chk($sformatf("v%0d_valid", i), {31'd0, or_valid_ex}, vecs[i].ev);
      chk($sformatf("v%0d_rd_wr_en", i), {31'd0, or_rd_wr_en_ex}, vecs[i].ewe);
      chk($sformatf("v%0d_is_load", i), {31'd0, or_is_load_ex}, vecs[i].eld);
      chk($sformatf("v%0d_stall_cnt", i), {16'd0, or_stall_cnt}, vecs[i].ecs);
      chk($sformatf("v%0d_flush_cnt", i), {16'd0, or_flush_cnt}, vecs[i].ecf);
      if (vecs[i].ev[0]) begin
        chk($sformatf("v%0d_pc", i), or_pc_ex, vecs[i].epc);
        chk($sformatf("v%0d_rs1", i), or_rs1_ex, vecs[i].ers1);
        chk($sformatf("v%0d_rs2", i), or_rs2_ex, vecs[i].ers2);
        chk($sformatf("v%0d_rd_addr", i), {27'd0, or_rd_addr_ex}, vecs[i].erd);
        chk($sformatf("v%0d_imm", i), or_imm_ex, vecs[i].eimm);
        chk($sformatf("v%0d_alu_op", i), {28'd0, or_alu_op_ex}, vecs[i].eop);
      end
    end

    // Mid-stream reset while MEM also stalls: o_stall_id follows i_stall_mem.
    i_rst = 1'b1;
    i_stall_mem = 1'b1;
    #1;
    chk("midrst_stall_id", {31'd0, o_stall_id}, 1);
    tick();
    chk("midrst_valid", {31'd0, or_valid_ex}, 0);
    chk("midrst_pc", or_pc_ex, 0);
    chk("midrst_rs2", or_rs2_ex, 0);
    chk("midrst_imm", or_imm_ex, 0);
    chk("midrst_rd_addr", {27'd0, or_rd_addr_ex}, 0);
    chk("midrst_rs1_addr", {27'd0, or_rs1_addr_ex}, 0);
    chk("midrst_stall_cnt", {16'd0, or_stall_cnt}, 0);
    chk("midrst_flush_cnt", {16'd0, or_flush_cnt}, 0);
    chk("midrst_sat_stall_cnt", {30'd0, s_stall_cnt}, 0);
    i_rst = 1'b0;
    i_stall_mem = 1'b0;

    // Repeated load-use pairs: lw x3 then a reader of x3.
    for (int k = 1; k <= 5; k++) begin
      set_id(1'b1, 32'h300, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 32'h304, 5'd3, 5'd1, 5'd4, 1'b0, 1'b0);
      #1;
      chk($sformatf("luh%0d_stall_id", k), {31'd0, o_stall_id}, 1);
      tick();
      chk($sformatf("luh%0d_valid", k), {31'd0, or_valid_ex}, 0);
      chk($sformatf("luh%0d_stall_cnt", k), {16'd0, or_stall_cnt}, k);
      chk($sformatf("luh%0d_sat_stall_cnt", k), {30'd0, s_stall_cnt}, (k > 3) ? 3 : k);
    end

    for (int k = 1; k <= 5; k++) begin
      set_id(1'b1, 32'h400, 5'd1, 5'd2, 5'd5, 1'b0, 1'b1);
      tick();
      chk($sformatf("fl%0d_valid", k), {31'd0, or_valid_ex}, 0);
      chk($sformatf("fl%0d_flush_cnt", k), {16'd0, or_flush_cnt}, k);
      chk($sformatf("fl%0d_sat_flush_cnt", k), {30'd0, s_flush_cnt}, (k > 3) ? 3 : k);
    end
    chk("sat_stall_hold", {30'd0, s_stall_cnt}, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
